// File: rtl/cla_seq_adder.sv
// cla_seq_adder: multi-cycle carry-lookahead adder/subtractor.
//
// Each RUN cycle resolves one GROUP-bit slice of the operands. A two-level
// lookahead network computes the slice's carries, and the group carry-out is
// registered for the next slice. A full operation takes NG = WIDTH/GROUP
// cycles. Valid/ready handshakes are used on both the operand and result sides.
//
// Ports:
//   i_clk        rising-edge clock
//   i_rst        synchronous reset, active-high
//   i_in_valid   operands present on i_a/i_b/i_cin/i_sub
//   o_in_ready   block can accept operands this cycle
//   i_a, i_b     operands (WIDTH bits)
//   i_cin        carry-in, ignored when i_sub=1
//   i_sub        1: a - b, 0: a + b + cin
//   o_out_valid  result held on o_sum/o_cout/o_ovf
//   i_out_ready  consumer takes the result this cycle
//   o_sum        result (WIDTH bits)
//   o_cout       carry out of MSB (subtract: 1 = no borrow)
//   o_ovf        signed overflow
//   o_busy       high while slices are being resolved

module cla_seq_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned GROUP = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    input  logic             i_sub,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf,
    output logic             o_busy
);

    localparam int unsigned NG = WIDTH / GROUP;
    localparam int unsigned CW = (NG > 1) ? $clog2(NG) : 1;
    localparam logic [WIDTH-1:0] SliceMask = WIDTH'({GROUP{1'b1}});

    generate
        if (((WIDTH % GROUP) != 0) || (GROUP < 2)) begin : g_param_check
            $fatal(1, "cla_seq_adder: WIDTH must be a multiple of GROUP and GROUP must be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_a, w_a_nxt;
    logic [WIDTH-1:0] r_b, w_b_nxt;
    logic [WIDTH-1:0] r_sum, w_sum_nxt;
    logic             r_carry, w_carry_nxt;
    logic             r_cout, w_cout_nxt;
    logic             r_ovf, w_ovf_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;

    logic             w_accept;
    logic             w_last;
    int unsigned      w_shift;
    logic [GROUP-1:0] w_a_slice;
    logic [GROUP-1:0] w_b_slice;
    logic [GROUP-1:0] w_g;
    logic [GROUP-1:0] w_p;
    logic [GROUP:0]   w_c;
    logic [GROUP-1:0] w_sum_slice;
    logic             w_term;
    logic             w_prod;

    // Slice selection: bit offset of the slice currently being resolved.
    always_comb begin
        w_shift   = 32'(r_cnt) * GROUP;
        w_a_slice = GROUP'(r_a >> w_shift);
        w_b_slice = GROUP'(r_b >> w_shift);
        w_g       = w_a_slice & w_b_slice;
        w_p       = w_a_slice ^ w_b_slice;
        w_last    = (r_cnt == CW'(NG - 1));
    end

    // Flattened lookahead: every c[i+1] is an independent sum of products
    //   g[i] | p[i]g[i-1] | ... | p[i]..p[1]g[0] | p[i]..p[0]c[0]
    // so no carry depends on another computed carry.
    always_comb begin
        w_c    = '0;
        w_term = 1'b0;
        w_prod = 1'b0;
        w_c[0] = r_carry;
        for (int i = 0; i < GROUP; i++) begin
            w_term = r_carry;
            for (int m = 0; m <= i; m++) begin
                w_term = w_term & w_p[m];
            end
            for (int j = 0; j <= i; j++) begin
                w_prod = w_g[j];
                for (int m = j + 1; m <= i; m++) begin
                    w_prod = w_prod & w_p[m];
                end
                w_term = w_term | w_prod;
            end
            w_c[i+1] = w_term;
        end
        w_sum_slice = w_p ^ w_c[GROUP-1:0];
    end

    // Next-state and handshake logic.
    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_sum_nxt   = r_sum;
        w_carry_nxt = r_carry;
        w_cout_nxt  = r_cout;
        w_ovf_nxt   = r_ovf;
        w_cnt_nxt   = r_cnt;

        o_in_ready  = (r_state == StIdle) || ((r_state == StDone) && i_out_ready);
        w_accept    = i_in_valid && o_in_ready;

        case (r_state)
            StIdle: begin
                // Loading handled below, shared with back-to-back accept.
            end
            StRun: begin
                w_sum_nxt   = (r_sum & ~(SliceMask << w_shift)) |
                              (WIDTH'(w_sum_slice) << w_shift);
                w_carry_nxt = w_c[GROUP];
                w_cnt_nxt   = r_cnt + 1'b1;
                if (w_last) begin
                    w_cout_nxt  = w_c[GROUP];
                    // Carry into the MSB differs from carry out => signed overflow.
                    w_ovf_nxt   = w_c[GROUP] ^ w_c[GROUP-1];
                    w_state_nxt = StDone;
                end
            end
            StDone: begin
                if (i_out_ready) begin
                    w_state_nxt = StIdle;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase

        // Accept is only possible in IDLE or on a DONE transfer.
        if (w_accept) begin
            w_a_nxt     = i_a;
            // Subtraction as a + ~b + 1; i_cin is ignored in that case.
            w_b_nxt     = i_sub ? ~i_b : i_b;
            w_carry_nxt = i_sub | i_cin;
            w_cnt_nxt   = '0;
            w_state_nxt = StRun;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_sum   <= w_sum_nxt;
            r_carry <= w_carry_nxt;
            r_cout  <= w_cout_nxt;
            r_ovf   <= w_ovf_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Outputs come straight from registers, so they cannot glitch in DONE.
    assign o_out_valid = (r_state == StDone);
    assign o_busy      = (r_state == StRun);
    assign o_sum       = r_sum;
    assign o_cout      = r_cout;
    assign o_ovf       = r_ovf;

endmodule

// File: doc/cla_seq_adder.md
Name: cla_seq_adder

Overview:
Parametrised multi-cycle carry-lookahead adder/subtractor. It generalises the fixed 2-bit carry-generate stage to a configurable lookahead group width. Each cycle it resolves one GROUP-bit slice with full lookahead and passes the group carry to the next slice through a register. It sits in the datapath library as the area-lean alternative to the fully combinational CLA, with a valid/ready interface on both sides.

Parameters:
WIDTH, 16, operand and result width in bits; must be a multiple of GROUP.
GROUP, 4, bits resolved per cycle by the lookahead carry network; must be >= 2.
NG (localparam), WIDTH/GROUP, number of slice cycles per operation.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  operands present
in_ready  out  1  block can accept operands this cycle
a  in  WIDTH  operand A
b  in  WIDTH  operand B
cin  in  1  carry-in; ignored when sub=1
sub  in  1  1: compute a - b; 0: compute a + b + cin
out_valid  out  1  result held on sum/cout/ovf
out_ready  in  1  consumer takes result this cycle
sum  out  WIDTH  result
cout  out  1  carry out of MSB (for sub: 1 = no borrow)
ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB
busy  out  1  high in RUN

Behaviour:
- FSM states IDLE, RUN, DONE. Reset (rst=1 at clk edge) forces IDLE regardless of state.
- Reset values: in_ready=1 (combinational from IDLE), out_valid=0, busy=0, sum=0, cout=0, ovf=0, slice counter=0, carry register=0.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Accept = in_valid & in_ready.
- On accept: register a; register b as b (sub=0) or ~b (sub=1); carry register = cin (sub=0) or 1 (sub=1); counter=0; go to RUN.
- RUN, each cycle on slice k = counter:
  - g = a[k]&b[k] and p = a[k]^b[k], bitwise on the slice.
  - Carries are computed by lookahead from the carry register: c[i+1] = g[i] | (p[i]&c[i]), flattened to two-level sum-of-products per bit, with no ripple chain.
  - sum slice = p ^ c[GROUP-1:0]; carry register = c[GROUP]; counter += 1.
- Slice NG-1 in RUN: also record carry into MSB (c[GROUP-1] of that slice) for ovf. Set cout = c[GROUP] and go to DONE.
- Latency: operands accepted at edge T give out_valid=1 after edge T+NG. Example: NG=4 gives 4 cycles.
- DONE: out_valid=1; sum/cout/ovf stable until transfer (out_valid & out_ready).
  - On transfer with no new accept: go to IDLE, out_valid=0.
  - On transfer with simultaneous accept: go directly to RUN with the new operands (back-to-back). Sustained throughput is one result per NG cycles.
- in_ready=0 throughout RUN; in_valid is ignored there and no operands are dropped silently, because the producer must hold them.
- sum/cout/ovf are don't-care outside DONE but must not glitch within DONE.
- Reset mid-RUN or mid-DONE discards the operation: next cycle IDLE, out_valid=0, in_ready=1.
- WIDTH==GROUP (NG=1) is legal: single RUN cycle, latency 1.
- Elaboration check: fatal error if WIDTH%GROUP!=0 or GROUP<2.

Test Plan:
1. WIDTH=16, GROUP=4: a=0x00FF, b=0x0001, cin=0, sub=0 -> out_valid exactly 4 cycles after accept; sum=0x0100, cout=0, ovf=0.
2. Full carry propagation: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
3. Subtract: a=0x0005, b=0x0007, sub=1, cin=1 (ignored) -> sum=0xFFFE, cout=0, ovf=0. Then a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
4. Backpressure and back-to-back: hold out_ready=0 for 3 cycles in DONE -> result stable, in_ready=0. Raise out_ready with in_valid=1 (a=0x1234, b=0x1111) -> same-cycle accept; next out_valid 4 cycles later with sum=0x2345.
5. Reset mid-operation: assert rst for 1 cycle two cycles after accept -> next cycle out_valid=0, in_ready=1, busy=0. The subsequent op 0x0001+0x0001 yields 0x0002 with no stale carry.
6. Randomised 1000 ops at WIDTH=16/GROUP=4 and WIDTH=12/GROUP=3 (plus WIDTH=GROUP=4) with random out_ready -> sum/cout/ovf match the reference model; no lost or duplicated results.
